// File: rtl/inst_encode_loader_pkg.sv
// Shared types for the instruction-encode loader: format codes, opcode constants
// and loader FSM states.
package inst_encode_loader_pkg;

   typedef enum logic [2:0] {
      FmtR = 3'd0,
      FmtI = 3'd1,
      FmtS = 3'd2,
      FmtU = 3'd3,
      FmtB = 3'd4,
      FmtJ = 3'd5
   } fmt_e;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/inst_encode_loader_encode_inst.sv
// Combinational RV32I field-to-word encoder, the inverse of the pipeline decoder.
// With INST_ENCODE_CHECK_EN defined, also flags fields that cannot round-trip.
module encode_inst
   import inst_encode_loader_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        bad
);

   always_comb begin
      word = '0;
      case (fmt)
         FmtR:    word = {funct7, rs2, rs1, funct3, rd, opcode};
         FmtI:    word = {imm[11:0], rs1, funct3, rd, opcode};
         FmtS:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FmtB:    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FmtU:    word = {imm[31:12], rd, opcode};
         FmtJ:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: word = '0;
      endcase
   end

`ifdef INST_ENCODE_CHECK_EN
   // Immediate must be the sign extension of the bits the format can hold.
   always_comb begin
      bad = (opcode[1:0] != 2'b11);
      case (fmt)
         FmtR: ;
         FmtI, FmtS: if (imm[31:11] != {21{imm[11]}}) bad = 1'b1;
         FmtB: if ((imm[31:12] != {20{imm[12]}}) || imm[0]) bad = 1'b1;
         FmtJ: if ((imm[31:20] != {12{imm[20]}}) || imm[0]) bad = 1'b1;
         FmtU: if (imm[11:0] != 12'h000) bad = 1'b1;
         default: bad = 1'b1;
      endcase
   end
`else
   assign bad = 1'b0;
`endif

endmodule

// File: rtl/inst_encode_loader.sv
// Program loader: encodes instruction descriptions, queues them in a FIFO and writes
// them to sequential instruction-memory addresses. INST_ENCODE_CHECK_EN enables error.
module inst_encode_loader
   import inst_encode_loader_pkg::*;
#(
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_type,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   input  logic              mem_wr_ready,
   output logic              busy,
   output logic              done,
   output logic [15:0]       count,
   output logic              error
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic [31:0]       fifo_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       count_q;
   logic [31:0]       enc_word;
   logic              enc_bad;
   logic              empty, full, push, pop, start_ok;

   encode_inst u_encode (
      .fmt    (in_type),
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .word   (enc_word),
      .bad    (enc_bad)
   );

   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == (PTR_W + 1)'(DEPTH));
   assign in_ready    = (state_q == StLoad) && !full;
   assign push        = in_valid && in_ready;
   assign mem_wr_en   = !empty;
   assign pop         = mem_wr_en && mem_wr_ready;
   assign mem_wr_data = empty ? 32'h0 : fifo_q[rd_ptr_q];
   assign mem_wr_addr = addr_q;
   assign count       = count_q;
   assign busy        = (state_q == StLoad) || (state_q == StDrain);
   assign done        = (state_q == StDone);
   assign start_ok    = start && ((state_q == StIdle) || (state_q == StDone));

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + (PTR_W + 1)'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - (PTR_W + 1)'(1);
      end
   end

   // DRAIN looks at next occupancy so done rises the cycle after the final write.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StLoad;
         StLoad:         if (push && in_last) state_d = StDrain;
         StDrain:        if (cnt_d == '0) state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= BASE_ADDR;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (start_ok) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
         end else if (pop) begin
            addr_q  <= addr_q + ADDR_W'(4);
            count_q <= count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= enc_word;
   end

`ifdef INST_ENCODE_CHECK_EN
   logic error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else if (start_ok) begin
         error_q <= 1'b0;
      end else if (push && enc_bad) begin
         error_q <= 1'b1;
      end
   end

   assign error = error_q;
`else
   // The encoder drives a constant 0 flag when checking is not built.
   assign error = enc_bad;
`endif

endmodule

// File: doc/inst_encode_loader.md
# inst_encode_loader

Program loader that encodes field-level RV32I instruction descriptions into 32-bit instruction words and writes them sequentially into instruction memory. The encoding is the exact inverse of the pipeline's instruction decode: decoding any emitted word returns the fields that were pushed. It sits between the bench/boot-time program source and the instruction memory write port, and buffers encoded words in a small FIFO so memory backpressure does not stall the source.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- ADDR_W, 32, memory address width
- BASE_ADDR, 0, first write address after `start`; must be 4-byte aligned

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  pulse; begins a load at BASE_ADDR; clears `done`, `count` and `error`
- in_valid  in  1  instruction description valid
- in_ready  out  1  loader accepts this cycle
- in_type  in  3  instruction format code from package: R=0, I=1, S=2, U=3, B=4, J=5; 6 and 7 are invalid
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field
- in_imm  in  32  immediate, in the same sign-extended form the decoder produces
- in_last  in  1  marks the final instruction of the program
- mem_wr_en  out  1  write request; equals FIFO not-empty
- mem_wr_addr  out  ADDR_W  byte address of the write
- mem_wr_data  out  32  encoded word (FIFO head)
- mem_wr_ready  in  1  memory accepts the write
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in DONE
- count  out  16  words written since `start`; wraps at 2^16
- error  out  1  sticky encode error; tied to 0 unless the check is compiled in

## Operation
- FSM states and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → DRAIN when a beat with `in_last=1` is accepted.
  - DRAIN → DONE when the FIFO is empty and no write is pending.
  - DONE → LOAD on `start`.
  - `start` is ignored in LOAD and DRAIN.
- `in_ready` = (state == LOAD) && !full.
  - There is no pass-through: a full FIFO blocks input even if a pop happens in the same cycle.
  - An accept is `in_valid && in_ready`.
- Encoding is combinational on accept; the word is pushed to the FIFO.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Invalid type: 32'h0000_0000.
  - Fields a format does not use are ignored; immediate bits outside the format are truncated.
- A write transfer is `mem_wr_en && mem_wr_ready`. On each transfer: pop the FIFO, add 4 to `mem_wr_addr` (wraps modulo 2^ADDR_W), increment `count`.
- Simultaneous push and pop keep the occupancy unchanged.
- `start` sets `mem_wr_addr` to BASE_ADDR. The FIFO is always empty in IDLE and DONE.

## Timing
- Reset values:
  - `in_ready` 0, `mem_wr_en` 0, `mem_wr_addr` BASE_ADDR, `mem_wr_data` 0.
  - `busy` 0, `done` 0, `count` 0, `error` 0.
  - State IDLE, FIFO empty.
- `start` is sampled at cycle N. `in_ready` can be high from N+1.
- A beat accepted at cycle N drives `mem_wr_en` from N+1 at the earliest.
- After the last write transfer at cycle M: `done` and `!busy` from M+1.
- `mem_wr_addr`, `mem_wr_data` and `mem_wr_en` hold stable while `mem_wr_ready` is low.
- Reset asserted mid-load flushes the FIFO and returns every output to its reset value immediately. No further writes occur.

## Configuration
- `INST_ENCODE_CHECK_EN` defined — each accepted beat is checked; any violation sets `error` (sticky until `start`/reset). The word is still written, truncated. Violations:
  - I/S: imm is not a 12-bit signed value.
  - B: imm is not a 13-bit signed value, or imm[0] is 1.
  - J: imm is not a 21-bit signed value, or imm[0] is 1.
  - U: imm[11:0] is not 0.
  - in_type is 6 or 7.
  - in_opcode[1:0] is not 2'b11.
- Undefined — no checking logic is built; `error` is tied to 0; truncation is silent.

## Structure
- Shared package: the format-code enum (R/I/S/U/B/J), the opcode constants already used by decode, and the FSM state enum.
- One sub-module: `encode_inst`, purely combinational, taking fields plus type and producing the word plus a check flag. The loader instantiates it at the FIFO input; the FIFO and FSM are inline.

## Test plan
- `start`, then addi x1,x0,5 (I, opcode 0x13, rd=1, imm=5, last) → one write, addr 0x0, data 0x00500093; `done` high the cycle after the write; `count`=1.
- add x3,x1,x2 (R, 0x33) then sw x2,8(x1) (S, 0x23, funct3=2, last) → writes 0x002081B3 @0x0, 0x0020A423 @0x4.
- beq x1,x2,-4; jal x1,2048; lui x5,0x12345000 → 0xFE208EE3, 0x001000EF, 0x123452B7 at consecutive addresses.
- Hold `mem_wr_ready`=0 and push continuously → `in_ready` drops after DEPTH accepts; release → all words written in order with no loss or duplication.
- Reset asserted while in DRAIN with 2 entries queued → `mem_wr_en`=0, `busy`=0, `count`=0 immediately; no writes afterwards.
- With `INST_ENCODE_CHECK_EN`: addi with imm=4096 → `error`=1 and word 0x00000093 written; `start` clears `error`.
